// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants and the fetch FSM state type.
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_t;
endpackage

// File: rtl/pc_redirect_mux.sv
// pc_redirect_mux: redirect detect, jump-over-branch target select and alignment.
// MISALIGN_TRAP_EN keeps target[1:0] and flags misaligned redirects instead of clearing them.
module pc_redirect_mux #(
    parameter int XLEN = 32
) (
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic            redirect,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);
    logic [XLEN-1:0] raw;
    assign redirect = jump | branch_taken;
    assign raw = jump ? jump_target : branch_target;
`ifdef MISALIGN_TRAP_EN
    assign target = raw;
    assign misaligned = redirect & (raw[1:0] != 2'b00);
`else
    assign target = raw & ~XLEN'(3);
    assign misaligned = 1'b0;
`endif
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: RV32I program counter and req/ack instruction-fetch stage.
// Define MISALIGN_TRAP_EN to add misalign_trap and park in HOLD on misaligned redirects.
module fetch_pc_unit #(
    parameter int              XLEN     = rv32i_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            misalign_trap
`endif
);
    import rv32i_pkg::*;
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d, ipc_q, ipc_d, tgt, nxt;
    logic [31:0]     instr_q, instr_d;
    logic            req_q, req_d, valid_q, valid_d, kill_q, kill_d, trapped_q, trapped_d;
    logic            redirect, misaligned;
    pc_redirect_mux #(.XLEN(XLEN)) u_mux (
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .redirect     (redirect),
        .target       (tgt),
        .misaligned   (misaligned)
    );
    assign imem_req    = req_q;
    assign imem_addr   = addr_q & ~XLEN'(3);
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign nxt         = imem_addr + XLEN'(4);
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        req_d     = req_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        kill_d    = kill_q;
        trapped_d = trapped_q;
        if (redirect && misaligned) begin
            state_d   = HOLD;
            req_d     = 1'b0;
            valid_d   = 1'b0;
            kill_d    = 1'b0;
            trapped_d = 1'b1;
        end else if (redirect) begin
            // an unanswered request stays on the bus; its data is discarded later via kill
            state_d   = FETCH;
            req_d     = 1'b1;
            valid_d   = 1'b0;
            pc_d      = tgt;
            trapped_d = 1'b0;
            kill_d    = (state_q == FETCH) && !imem_ack;
            addr_d    = kill_d ? addr_q : tgt;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
                FETCH: begin
                    if (imem_ack && kill_q) begin
                        kill_d  = 1'b0;
                        addr_d  = pc_q;
                        valid_d = 1'b0;
                    end else if (imem_ack) begin
                        instr_d = imem_rdata;
                        ipc_d   = imem_addr;
                        valid_d = 1'b1;
                        pc_d    = nxt;
                        addr_d  = nxt;
                        state_d = stall ? HOLD : FETCH;
                        req_d   = !stall;
                    end else begin
                        valid_d = stall && valid_q;
                    end
                end
                default: begin
                    if (!stall && !trapped_q) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            instr_q   <= RV32I_NOP;
            ipc_q     <= RESET_PC;
            kill_q    <= 1'b0;
            trapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            ipc_q     <= ipc_d;
            kill_q    <= kill_d;
            trapped_q <= trapped_d;
        end
    end
`ifdef MISALIGN_TRAP_EN
    logic trap_q;
    assign misalign_trap = trap_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= redirect & misaligned;
        end
    end
`endif
endmodule
